adbg_chain_select: RTL and testbench

//  Parametrised debug-chain selector for the advanced debug interface, in the TCK domain between the TAP and N debug modules (AXI, per-core CPU, ...).

---
 rtl/adbg_pkg.sv | 30 +++
 rtl/adbg_sel_status_sr.sv | 28 ++
 rtl/adbg_chain_select.sv | 122 ++++++++++++
 tb/tb_adbg_chain_select.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adbg_pkg.sv
// Shared constants, status word layout and DR field offsets for the debug chain selector.
// Used by adbg_chain_select and adbg_sel_status_sr.
package adbg_pkg;

    localparam logic [7:0] ADBG_STATUS_MAGIC = 8'hA5;
    localparam int         ADBG_STATUS_W     = 16;
    localparam int         ADBG_STATUS_ID_W  = 5;

    typedef struct packed {
        logic [7:0]                  magic;
        logic                        sel_err;
        logic                        sel_busy;
        logic                        rsvd;
        logic [ADBG_STATUS_ID_W-1:0] module_id;
    } status_t;

    // The command bit sits at the top of the DR, followed by the ID, then the parity bit.
    function automatic int dr_cmd_pos(input int data_len);
        return data_len - 1;
    endfunction

    function automatic int dr_id_msb(input int data_len);
        return data_len - 2;
    endfunction

    function automatic int dr_parity_pos(input int data_len, input int id_w);
        return data_len - 2 - id_w;
    endfunction

endpackage

// File: rtl/adbg_sel_status_sr.sv
// 16-bit status shift register: parallel load on capture, shift right with zero fill.
// Bit 0 is the serial output.
module adbg_sel_status_sr
    import adbg_pkg::*;
(
    input  logic                     tck_i,
    input  logic                     trstn_i,
    input  logic                     load_i,
    input  logic                     shift_i,
    input  logic [ADBG_STATUS_W-1:0] load_val_i,
    output logic                     tdo_o
);

    logic [ADBG_STATUS_W-1:0] status_sr;

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            status_sr <= '0;
        end else if (load_i) begin
            status_sr <= load_val_i;
        end else if (shift_i) begin
            status_sr <= {1'b0, status_sr[ADBG_STATUS_W-1:1]};
        end
    end

    assign tdo_o = status_sr[0];

endmodule

// File: rtl/adbg_chain_select.sv
// Debug-chain selector: shared DR, module-ID register, one-hot selects and TDO mux,
// with ID range checking, sticky error/busy flags and a status word. Option: ADBG_SEL_PARITY_EN.
module adbg_chain_select
    import adbg_pkg::*;
#(
    parameter int NB_MODULES   = 4,
    parameter int ID_W         = 5,
    parameter int DATA_LEN     = 64,
    parameter int RESET_MODULE = 0
) (
    input  logic                  tck_i,
    input  logic                  trstn_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic                  debug_select_i,
    input  logic                  capture_dr_i,
    input  logic                  shift_dr_i,
    input  logic                  update_dr_i,
    output logic [DATA_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0] module_select_o,
    input  logic [NB_MODULES-1:0] module_inhibit_i,
    input  logic [NB_MODULES-1:0] module_tdo_i,
    output logic                  sel_err_o
);

    localparam int              CMD_POS = dr_cmd_pos(DATA_LEN);
    localparam int              ID_MSB  = dr_id_msb(DATA_LEN);
    localparam logic [ID_W:0]   NB_ID   = (ID_W+1)'(NB_MODULES);

    logic [DATA_LEN-1:0] shift_sr;
    logic [ID_W-1:0]     module_id_q;
    logic                sel_err_q;
    logic                sel_busy_q;
    logic                status_pend_q;

    logic                cmd;
    logic [ID_W-1:0]     id_in;
    logic                parity_ok;
    logic                sel_event;
    logic                nonsel_update;
    logic                status_load;
    logic                status_shift;
    logic                status_tdo;
    status_t             status_word;

    assign cmd           = shift_sr[CMD_POS];
    assign id_in         = shift_sr[ID_MSB -: ID_W];
    assign sel_event     = debug_select_i & update_dr_i & cmd;
    assign nonsel_update = debug_select_i & update_dr_i & ~cmd;

`ifdef ADBG_SEL_PARITY_EN
    localparam int PAR_POS = dr_parity_pos(DATA_LEN, ID_W);
    assign parity_ok = (shift_sr[PAR_POS] == ^{cmd, id_in});
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            shift_sr <= '0;
        end else if (debug_select_i && shift_dr_i) begin
            shift_sr <= {tdi_i, shift_sr[DATA_LEN-1:1]};
        end
    end

    // Inhibit is checked first so a busy module never sees its error flag disturbed.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            module_id_q   <= ID_W'(RESET_MODULE);
            sel_err_q     <= 1'b0;
            sel_busy_q    <= 1'b0;
            status_pend_q <= 1'b0;
        end else if (sel_event) begin
            status_pend_q <= 1'b1;
            if (|module_inhibit_i) begin
                sel_busy_q <= 1'b1;
            end else if (({1'b0, id_in} >= NB_ID) || !parity_ok) begin
                sel_err_q  <= 1'b1;
                sel_busy_q <= 1'b0;
            end else begin
                module_id_q <= id_in;
                sel_err_q   <= 1'b0;
                sel_busy_q  <= 1'b0;
            end
        end else if (nonsel_update) begin
            status_pend_q <= 1'b0;
        end
    end

    always_comb begin
        status_word           = '0;
        status_word.magic     = ADBG_STATUS_MAGIC;
        status_word.sel_err   = sel_err_q;
        status_word.sel_busy  = sel_busy_q;
        status_word.rsvd      = 1'b0;
        status_word.module_id = ADBG_STATUS_ID_W'(module_id_q);
    end

    assign status_load  = capture_dr_i & debug_select_i & status_pend_q & ~update_dr_i;
    assign status_shift = shift_dr_i & debug_select_i & status_pend_q;

    adbg_sel_status_sr u_status_sr (
        .tck_i      (tck_i),
        .trstn_i    (trstn_i),
        .load_i     (status_load),
        .shift_i    (status_shift),
        .load_val_i (status_word),
        .tdo_o      (status_tdo)
    );

    always_comb begin
        module_select_o = '0;
        for (int i = 0; i < NB_MODULES; i++) begin
            module_select_o[i] = (module_id_q == ID_W'(i));
        end
    end

    assign tdo_o           = status_pend_q ? status_tdo : |(module_select_o & module_tdo_i);
    assign data_register_o = shift_sr;
    assign sel_err_o       = sel_err_q;

endmodule

// File: tb/tb_adbg_chain_select.sv
// Directed bench for adbg_chain_select with hand-computed expected values.
// The wrong-parity case runs only when ADBG_SEL_PARITY_EN is defined.
module tb_adbg_chain_select;

    logic        tck_i = 1'b0;
    logic        trstn_i;
    logic        tdi_i;
    logic        tdo_o;
    logic        debug_select_i;
    logic        capture_dr_i;
    logic        shift_dr_i;
    logic        update_dr_i;
    logic [63:0] data_register_o;
    logic [3:0]  module_select_o;
    logic [3:0]  module_inhibit_i;
    logic [3:0]  module_tdo_i;
    logic        sel_err_o;

    int checks   = 0;
    int failures = 0;

    adbg_chain_select #(
        .NB_MODULES   (4),
        .ID_W         (5),
        .DATA_LEN     (64),
        .RESET_MODULE (0)
    ) dut (
        .tck_i            (tck_i),
        .trstn_i          (trstn_i),
        .tdi_i            (tdi_i),
        .tdo_o            (tdo_o),
        .debug_select_i   (debug_select_i),
        .capture_dr_i     (capture_dr_i),
        .shift_dr_i       (shift_dr_i),
        .update_dr_i      (update_dr_i),
        .data_register_o  (data_register_o),
        .module_select_o  (module_select_o),
        .module_inhibit_i (module_inhibit_i),
        .module_tdo_i     (module_tdo_i),
        .sel_err_o        (sel_err_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic shift_word(input logic [63:0] v);
        shift_dr_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tdi_i = v[i];
            tick();
        end
        shift_dr_i = 1'b0;
        tdi_i      = 1'b0;
    endtask

    task automatic do_update();
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
    endtask

    function automatic logic [63:0] sel_word(input logic [4:0] id, input logic good_par);
        logic [63:0] v;
        v        = '0;
        v[63]    = 1'b1;
        v[62:58] = id;
        v[57]    = good_par ? ^{1'b1, id} : ~(^{1'b1, id});
        return v;
    endfunction

    task automatic do_select(input logic [4:0] id, input logic good_par);
        shift_word(sel_word(id, good_par));
        do_update();
    endtask

    task automatic nonsel_update();
        shift_word(64'h0);
        do_update();
    endtask

    task automatic read_status(output logic [15:0] st);
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        tdi_i        = 1'b0;
        shift_dr_i   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            st[i] = tdo_o;
            tick();
        end
        shift_dr_i = 1'b0;
    endtask

    logic [15:0] st;

    initial begin
        trstn_i          = 1'b0;
        tdi_i            = 1'b0;
        debug_select_i   = 1'b1;
        capture_dr_i     = 1'b0;
        shift_dr_i       = 1'b0;
        update_dr_i      = 1'b0;
        module_inhibit_i = 4'b0000;
        module_tdo_i     = 4'b0000;
        repeat (3) tick();

        chk("rst_dr", data_register_o, 64'h0);
        chk("rst_sel", module_select_o, 4'b0001);
        chk("rst_err", sel_err_o, 1'b0);
        trstn_i = 1'b1;
        tick();
        module_tdo_i = 4'b0001; #1;
        chk("rst_tdo_hi", tdo_o, 1'b1);
        module_tdo_i = 4'b1110; #1;
        chk("rst_tdo_lo", tdo_o, 1'b0);

        do_select(5'd2, 1'b1);
        chk("sel2_dr", data_register_o, sel_word(5'd2, 1'b1));
        chk("sel2_sel", module_select_o, 4'b0100);
        read_status(st);
        chk("sel2_status", st, 16'hA502);
        nonsel_update();
        module_tdo_i = 4'b0100; #1;
        chk("sel2_tdo_hi", tdo_o, 1'b1);
        module_tdo_i = 4'b1011; #1;
        chk("sel2_tdo_lo", tdo_o, 1'b0);

        do_select(5'd7, 1'b1);
        chk("bad7_sel", module_select_o, 4'b0100);
        chk("bad7_err", sel_err_o, 1'b1);
        read_status(st);
        chk("bad7_status", st, 16'hA582);

        do_select(5'd1, 1'b1);
        chk("sel1_sel", module_select_o, 4'b0010);
        chk("sel1_err", sel_err_o, 1'b0);
        read_status(st);
        chk("sel1_status", st, 16'hA501);

        module_inhibit_i = 4'b0010;
        do_select(5'd3, 1'b1);
        chk("inh_sel", module_select_o, 4'b0010);
        read_status(st);
        chk("inh_status", st, 16'hA541);
        do_select(5'd7, 1'b1);
        chk("inh_bad_err", sel_err_o, 1'b0);
        module_inhibit_i = 4'b0000;
        do_select(5'd3, 1'b1);
        chk("sel3_sel", module_select_o, 4'b1000);
        read_status(st);
        chk("sel3_status", st, 16'hA503);

        do_select(5'd4, 1'b1);
        chk("bad4_sel", module_select_o, 4'b1000);
        read_status(st);
        chk("bad4_status", st, 16'hA583);
        do_select(5'd31, 1'b1);
        chk("bad31_err", sel_err_o, 1'b1);
        do_select(5'd0, 1'b1);
        chk("sel0_sel", module_select_o, 4'b0001);
        chk("sel0_err", sel_err_o, 1'b0);

`ifdef ADBG_SEL_PARITY_EN
        do_select(5'd2, 1'b0);
        chk("par_sel", module_select_o, 4'b0001);
        chk("par_err", sel_err_o, 1'b1);
        read_status(st);
        chk("par_status", st, 16'hA580);
`endif

        do_select(5'd2, 1'b1);
        chk("pre_rst_sel", module_select_o, 4'b0100);
        shift_dr_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tdi_i = sel_word(5'd3, 1'b1) >> i;
            tick();
        end
        #1 trstn_i = 1'b0;
        #1;
        chk("mid_rst_dr", data_register_o, 64'h0);
        chk("mid_rst_sel", module_select_o, 4'b0001);
        chk("mid_rst_err", sel_err_o, 1'b0);
        module_tdo_i = 4'b0001; #1;
        chk("mid_rst_tdo", tdo_o, 1'b1);
        shift_dr_i = 1'b0;
        tdi_i      = 1'b0;
        tick();
        trstn_i = 1'b1;
        tick();
        do_select(5'd3, 1'b1);
        chk("post_rst_sel", module_select_o, 4'b1000);
        read_status(st);
        chk("post_rst_status", st, 16'hA503);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
